rs: RTL and testbench
=====================

Name: rs

Overview:
- Reservation-station block between dispatch (ID) and execute (EX) in the R10K-style out-of-order core.
- Holds five single-entry stations: ALU, FP1, FP2, LD, ST.
- Accepts one decoded ID_EX_PACKET per cycle and tracks operand readiness by snooping the CDB tag.
- Issues at most one ready instruction per cycle to EX.

Parameters:
- None. Station count (5) and kinds are fixed; types and widths come from the shared sys_defs definitions.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- input_pkt  input  $bits(ID_EX_PACKET)  dispatched instruction; uses valid, illegal, rd_mem, wr_mem, alu_func, T1, T2 (T1/T2 are TAG: tag, ready, valid).
- cdb  input  $bits(TAG)  completion broadcast; a broadcast is meaningful only when cdb.valid=1.
- rs_busy_alu  output  1  ALU station occupied.
- rs_busy_fp1  output  1  FP1 station occupied.
- rs_busy_fp2  output  1  FP2 station occupied.
- rs_busy_ld  output  1  LD station occupied.
- rs_busy_st  output  1  ST station occupied.
- issue_pkt  output  $bits(ID_EX_PACKET)  packet being issued; all zeros when issue=0.
- issue  output  1  issue_pkt is valid this cycle.

Behaviour:
- Reset (reset=0, asynchronous): all stations empty, all busy=0, issue=0, issue_pkt=0. Reset applied mid-operation discards all held entries.
- Dispatch accept condition: input_pkt.valid=1 and illegal=0. Routing, in priority order:
  - rd_mem=1 → LD.
  - else wr_mem=1 → ST.
  - else alu_func==ALU_MUL → FP1 if FP1 free, otherwise FP2.
  - else → ALU.
- Dispatch to a busy target is dropped with no state change. Upstream must stall using the rs_busy_* outputs.
- Busy outputs are the registered occupancy bits. A station issuing this cycle still reports busy and cannot accept a dispatch in the same cycle.
- Operand readiness: an operand with T.valid=0 (not needed) counts as ready. An operand with T.valid=1 is ready when T.ready=1.
- Wakeup: on each rising edge, for every occupied entry, if cdb.valid=1 and cdb.tag == Tn.tag and Tn.valid=1, set Tn.ready=1.
- Wakeup also applies to the packet being dispatched in the same cycle, so the stored operand is already ready.
- Issue (combinational from registered entry state): an entry is eligible when occupied and both operands are ready.
  - Fixed priority among eligible entries: ALU > FP1 > FP2 > LD > ST.
  - issue=1 and issue_pkt = the selected stored packet, with updated T1/T2.ready.
  - The selected entry clears at the next rising edge. No issue_pkt stall/ack input exists; EX always accepts.
- Latency: dispatch at edge N; earliest issue is the cycle after edge N. CDB wakeup at edge N allows issue in the following cycle.
- The CDB does not clear or alter entries other than ready bits. Non-matching tags and cdb.valid=0 are ignored.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- When defined: eligibility also counts an operand ready if the current cdb (valid=1, tag match) names it. The entry issues in the same cycle as the broadcast, and issue_pkt shows ready=1.
- When undefined: wakeup is registered only, giving one cycle of latency after the broadcast.

Decomposition:
- Shared package (sys_defs): ID_EX_PACKET, TAG struct, ALU_FUNC enum (ALU_ADD, ALU_MUL, ...), and an RS_KIND enum {RS_ALU, RS_FP1, RS_FP2, RS_LD, RS_ST}.
- Sub-module rs_entry: holds one packet plus occupancy; performs CDB wakeup and outputs ready/busy. rs instantiates five rs_entry copies, plus the routing and the priority issue selector.

Test Plan:
- Reset: reset=0 for one cycle → all busy=0, issue=0, issue_pkt=0.
- ADD T1=1, T2=2 (both valid, not ready) → rs_busy_alu=1, issue=0. cdb tag=1 valid → still no issue. cdb tag=2 → issue=1 next cycle with alu_func=ALU_ADD; rs_busy_alu=0 after that edge.
- LD (rd_mem=1, T 3/4), then ST (wr_mem=1, T 5/6) → rs_busy_ld=1 then rs_busy_st=1, ALU untouched. Broadcast tags 3,4,5,6 → LD issues before ST when both are eligible.
- Two MULs (T 5/6) → first sets rs_busy_fp1, second sets rs_busy_fp2. A third MUL is dropped, with no state change.
- Same-cycle: dispatch ADD T1=7 while cdb.tag=7 valid → stored T1.ready=1. Simultaneous-ready ALU and ST → ALU issues first, ST the following cycle.
- Operand T.valid=0, or illegal=1 / valid=0 packet → T.valid=0 operand is treated as ready and issues without any CDB; illegal or invalid packet leaves all busy=0.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared core definitions (sys_defs) used by the reservation station:
// CDB tag, ALU function codes, station kinds and the ID/EX packet.
package rs_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned NUM_RS = 5;

  // Physical-register tag as carried by operands and broadcast on the CDB
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
    logic             valid;
  } TAG;

  localparam int unsigned TAG_BITS = $bits(TAG);

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_SLT    = 5'h02,
    ALU_SLTU   = 5'h03,
    ALU_AND    = 5'h04,
    ALU_OR     = 5'h05,
    ALU_XOR    = 5'h06,
    ALU_SLL    = 5'h07,
    ALU_SRL    = 5'h08,
    ALU_SRA    = 5'h09,
    ALU_MUL    = 5'h0a,
    ALU_MULH   = 5'h0b,
    ALU_MULHSU = 5'h0c,
    ALU_MULHU  = 5'h0d
  } ALU_FUNC;

  // Station index order doubles as issue priority (lowest index wins)
  typedef enum logic [2:0] {
    RS_ALU = 3'd0,
    RS_FP1 = 3'd1,
    RS_FP2 = 3'd2,
    RS_LD  = 3'd3,
    RS_ST  = 3'd4
  } RS_KIND;

  typedef struct packed {
    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  inst;
    logic [REG_W-1:0] dest_reg_idx;
    ALU_FUNC          alu_func;
    logic             rd_mem;
    logic             wr_mem;
    logic             halt;
    logic             illegal;
    logic             valid;
    TAG               T1;
    TAG               T2;
  } ID_EX_PACKET;

  localparam int unsigned PKT_W = $bits(ID_EX_PACKET);

  // A broadcast matches an operand only if both are valid and tags agree
  function automatic logic tag_hit(input TAG t, input TAG b);
    return b.valid && t.valid && (t.tag == b.tag);
  endfunction

  // Operand with the broadcast applied to its ready bit
  function automatic TAG tag_wake(input TAG t, input TAG b);
    TAG r;
    r = t;
    if (tag_hit(t, b)) r.ready = 1'b1;
    return r;
  endfunction

  // Operands that are not needed count as ready
  function automatic logic operand_ready(input TAG t);
    return !t.valid || t.ready;
  endfunction

  // Packet with the broadcast applied to both operands
  function automatic ID_EX_PACKET wake_pkt(input ID_EX_PACKET p, input TAG b);
    ID_EX_PACKET r;
    r    = p;
    r.T1 = tag_wake(p.T1, b);
    r.T2 = tag_wake(p.T2, b);
    return r;
  endfunction

endpackage

// File: rtl/rs_entry.sv
// Single reservation-station slot: holds one packet, snoops the CDB for
// operand wakeup and reports occupancy and issue eligibility.
// RS_CDB_BYPASS_EN: the live CDB also counts toward eligibility/view.
module rs_entry
  import rs_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  ID_EX_PACKET load_pkt,
  input  TAG          cdb,
  output logic        busy,
  output logic        ready_c,
  output ID_EX_PACKET pkt_c
);

  ID_EX_PACKET entry_q;
  logic        busy_q;
  ID_EX_PACKET view;
  logic        cdb_unused;

  // The CDB ready bit carries no meaning for wakeup
  assign cdb_unused = cdb.ready;

  // Occupancy and stored packet; wakeup applies to held and incoming packets
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      entry_q <= '0;
    end else if (load) begin
      busy_q  <= 1'b1;
      entry_q <= wake_pkt(load_pkt, cdb);
    end else if (clear) begin
      busy_q  <= 1'b0;
    end else if (busy_q) begin
      entry_q <= wake_pkt(entry_q, cdb);
    end
  end

  // Packet as seen by the issue selector
  always_comb begin
    view = '0;
    if (busy_q) begin
`ifdef RS_CDB_BYPASS_EN
      view = wake_pkt(entry_q, cdb);
`else
      view = entry_q;
`endif
    end
  end

  // Eligible when occupied with both operands ready
  always_comb begin
    ready_c = busy_q && operand_ready(view.T1) && operand_ready(view.T2);
  end

  assign pkt_c = view;
  assign busy  = busy_q;

endmodule

// File: rtl/rs.sv
// Reservation station between dispatch and execute: five single-entry
// stations (ALU, FP1, FP2, LD, ST), CDB wakeup and fixed-priority issue.
// Optional build macro RS_CDB_BYPASS_EN lets a live CDB broadcast make an
// entry eligible in the same cycle; by default wakeup is registered only.
module rs
  import rs_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [PKT_W-1:0] input_pkt,
  input  logic [TAG_BITS-1:0] cdb,
  output logic             rs_busy_alu,
  output logic             rs_busy_fp1,
  output logic             rs_busy_fp2,
  output logic             rs_busy_ld,
  output logic             rs_busy_st,
  output logic [PKT_W-1:0] issue_pkt,
  output logic             issue
);

  ID_EX_PACKET        in_pkt;
  TAG                 cdb_tag;
  RS_KIND             target;
  logic               accept;
  logic [NUM_RS-1:0]  load_vec;
  logic [NUM_RS-1:0]  busy_vec;
  logic [NUM_RS-1:0]  ready_vec;
  logic [NUM_RS-1:0]  grant_vec;
  ID_EX_PACKET        entry_pkt [NUM_RS];
  ID_EX_PACKET        sel_pkt;

  assign in_pkt  = ID_EX_PACKET'(input_pkt);
  assign cdb_tag = TAG'(cdb);

  // Route an accepted dispatch to its station; busy targets drop the packet
  always_comb begin
    target   = RS_ALU;
    load_vec = '0;
    accept   = in_pkt.valid && !in_pkt.illegal;
    if (in_pkt.rd_mem) begin
      target = RS_LD;
    end else if (in_pkt.wr_mem) begin
      target = RS_ST;
    end else if (in_pkt.alu_func == ALU_MUL) begin
      target = busy_vec[RS_FP1] ? RS_FP2 : RS_FP1;
    end
    if (accept && !busy_vec[target]) begin
      load_vec = NUM_RS'(1) << target;
    end
  end

  // Five station slots, indexed by RS_KIND
  for (genvar g = 0; g < NUM_RS; g++) begin : g_entry
    rs_entry u_entry (
      .clock    (clock),
      .reset    (reset),
      .load     (load_vec[g]),
      .clear    (grant_vec[g]),
      .load_pkt (in_pkt),
      .cdb      (cdb_tag),
      .busy     (busy_vec[g]),
      .ready_c  (ready_vec[g]),
      .pkt_c    (entry_pkt[g])
    );
  end

  // Lowest-index eligible station wins: ALU > FP1 > FP2 > LD > ST
  always_comb begin
    grant_vec = ready_vec & (NUM_RS'(~ready_vec) + NUM_RS'(1));
  end

  // Issue mux; non-selected entries present zero so an OR-reduce suffices
  always_comb begin
    sel_pkt = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (grant_vec[i]) sel_pkt = sel_pkt | entry_pkt[i];
    end
  end

  assign issue       = |grant_vec;
  assign issue_pkt   = PKT_W'(sel_pkt);
  assign rs_busy_alu = busy_vec[RS_ALU];
  assign rs_busy_fp1 = busy_vec[RS_FP1];
  assign rs_busy_fp2 = busy_vec[RS_FP2];
  assign rs_busy_ld  = busy_vec[RS_LD];
  assign rs_busy_st  = busy_vec[RS_ST];

endmodule

// File: tb/tb_rs.sv
// Scoreboard bench for the reservation station: stimulus pushes expected
// issue packets, a negedge monitor pops and compares every issue.
module tb_rs;
  import rs_pkg::*;

  logic                clock;
  logic                reset;
  ID_EX_PACKET         in_pkt;
  TAG                  cdb;
  logic                rs_busy_alu, rs_busy_fp1, rs_busy_fp2, rs_busy_ld, rs_busy_st;
  logic [PKT_W-1:0]    issue_pkt;
  logic                issue;

  int                  errors = 0;
  int                  checks = 0;
  ID_EX_PACKET         exp_q[$];

  rs dut (
    .clock       (clock),
    .reset       (reset),
    .input_pkt   (in_pkt),
    .cdb         (cdb),
    .rs_busy_alu (rs_busy_alu),
    .rs_busy_fp1 (rs_busy_fp1),
    .rs_busy_fp2 (rs_busy_fp2),
    .rs_busy_ld  (rs_busy_ld),
    .rs_busy_st  (rs_busy_st),
    .issue_pkt   (issue_pkt),
    .issue       (issue)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic ID_EX_PACKET mk(input int id, input ALU_FUNC f, input logic rd,
                                     input logic wr, input logic [TAG_W-1:0] t1,
                                     input logic v1, input logic [TAG_W-1:0] t2,
                                     input logic v2);
    ID_EX_PACKET p;
    p              = '0;
    p.npc          = 32'h1000 + 32'(id) * 32'd4;
    p.inst         = 32'hA000_0000 | 32'(id);
    p.dest_reg_idx = 5'(id);
    p.alu_func     = f;
    p.rd_mem       = rd;
    p.wr_mem       = wr;
    p.valid        = 1'b1;
    p.T1.tag       = t1;
    p.T1.valid     = v1;
    p.T2.tag       = t2;
    p.T2.valid     = v2;
    return p;
  endfunction

  function automatic ID_EX_PACKET rdy(input ID_EX_PACKET p, input logic r1, input logic r2);
    ID_EX_PACKET q;
    q          = p;
    q.T1.ready = r1;
    q.T2.ready = r2;
    return q;
  endfunction

  function automatic logic [4:0] bv();
    return {rs_busy_alu, rs_busy_fp1, rs_busy_fp2, rs_busy_ld, rs_busy_st};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input ID_EX_PACKET p, input logic [TAG_W-1:0] t, input logic v);
    in_pkt    = p;
    cdb       = '0;
    cdb.tag   = t;
    cdb.valid = v;
    cyc();
    in_pkt = '0;
    cdb    = '0;
  endtask

  // Monitor: every issue must match the oldest expected packet
  always @(negedge clock) begin
    if (reset) begin
      if (issue) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got pkt %h expected no issue", issue_pkt);
        end else begin
          ID_EX_PACKET e;
          e = exp_q.pop_front();
          if (ID_EX_PACKET'(issue_pkt) !== e) begin
            errors++;
            $display("FAIL issue_pkt: got %h expected %h", issue_pkt, e);
          end
        end
      end else if (issue_pkt !== '0) begin
        checks++;
        errors++;
        $display("FAIL idle_pkt: got %h expected 0", issue_pkt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ID_EX_PACKET p;
    reset  = 1'b0;
    in_pkt = '0;
    cdb    = '0;

    // Reset state
    @(negedge clock);
    chk("reset_busy", bv(), 5'b00000);
    chk("reset_issue", {4'b0, issue}, 5'b0);
    chk("reset_pkt_zero", {4'b0, (issue_pkt == '0)}, 5'b1);
    @(negedge clock);
    reset = 1'b1;
    cyc();

    // ADD waits for both tags
    p = mk(1, ALU_ADD, 0, 0, 6'd1, 1, 6'd2, 1);
    drive(p, 0, 0);
    chk("alu_dispatch", bv(), 5'b10000);
    drive('0, 6'd1, 1);
    chk("alu_wait_t2", bv(), 5'b10000);
    exp_q.push_back(rdy(p, 1, 1));
    drive('0, 6'd2, 1);
    cyc();
    chk("alu_cleared", bv(), 5'b00000);

    // LD then ST, LD issues first
    p = mk(2, ALU_ADD, 1, 0, 6'd3, 1, 6'd4, 1);
    drive(p, 0, 0);
    chk("ld_dispatch", bv(), 5'b00010);
    exp_q.push_back(rdy(p, 1, 1));
    p = mk(3, ALU_ADD, 0, 1, 6'd5, 1, 6'd6, 1);
    drive(p, 0, 0);
    chk("st_dispatch", bv(), 5'b00011);
    drive('0, 6'd3, 1);
    chk("ld_wait", bv(), 5'b00011);
    drive('0, 6'd4, 1);
    drive('0, 6'd5, 1);
    chk("ld_issued", bv(), 5'b00001);
    exp_q.push_back(rdy(p, 1, 1));
    drive('0, 6'd6, 1);
    cyc();
    chk("st_cleared", bv(), 5'b00000);

    // MUL routing to FP1, FP2, third dropped
    p = mk(4, ALU_MUL, 0, 0, 6'd5, 1, 6'd6, 1);
    exp_q.push_back(rdy(p, 1, 1));
    drive(p, 0, 0);
    chk("mul_fp1", bv(), 5'b01000);
    p = mk(5, ALU_MUL, 0, 0, 6'd5, 1, 6'd6, 1);
    exp_q.push_back(rdy(p, 1, 1));
    drive(p, 0, 0);
    chk("mul_fp2", bv(), 5'b01100);
    drive(mk(6, ALU_MUL, 0, 0, 6'd9, 1, 6'd10, 1), 0, 0);
    chk("mul_drop", bv(), 5'b01100);
    drive('0, 6'd5, 1);
    drive('0, 6'd6, 1);
    cyc();
    cyc();
    chk("mul_cleared", bv(), 5'b00000);

    // Same-cycle wakeup at dispatch; ALU beats ST on a shared tag
    p = mk(7, ALU_ADD, 0, 0, 6'd7, 1, 6'd12, 1);
    exp_q.push_back(rdy(p, 1, 1));
    drive(p, 6'd7, 1);
    chk("same_cycle_alu", bv(), 5'b10000);
    p = mk(8, ALU_ADD, 0, 1, 6'd12, 1, 6'd12, 0);
    exp_q.push_back(rdy(p, 1, 0));
    drive(p, 0, 0);
    chk("alu_st_held", bv(), 5'b10001);
    drive('0, 6'd12, 1);
    cyc();
    cyc();
    chk("alu_st_cleared", bv(), 5'b00000);

    // LD beats ST when both wake on the same broadcast
    p = mk(9, ALU_ADD, 1, 0, 6'd8, 1, 6'd0, 0);
    exp_q.push_back(rdy(p, 1, 0));
    drive(p, 0, 0);
    p = mk(10, ALU_ADD, 0, 1, 6'd8, 1, 6'd8, 0);
    exp_q.push_back(rdy(p, 1, 0));
    drive(p, 0, 0);
    chk("ld_st_held", bv(), 5'b00011);
    drive('0, 6'd8, 1);
    cyc();
    cyc();
    chk("ld_st_cleared", bv(), 5'b00000);

    // Operands not needed: issues without any broadcast
    p = mk(11, ALU_SUB, 0, 0, 6'd20, 0, 6'd21, 0);
    exp_q.push_back(p);
    drive(p, 0, 0);
    chk("noop_dispatch", bv(), 5'b10000);
    cyc();
    chk("noop_cleared", bv(), 5'b00000);

    // Illegal and invalid packets are ignored
    p = mk(12, ALU_ADD, 0, 0, 6'd0, 0, 6'd0, 0);
    p.illegal = 1'b1;
    drive(p, 0, 0);
    chk("illegal_drop", bv(), 5'b00000);
    p = mk(13, ALU_MUL, 0, 0, 6'd0, 0, 6'd0, 0);
    p.valid = 1'b0;
    drive(p, 0, 0);
    chk("invalid_drop", bv(), 5'b00000);
    p = mk(14, ALU_ADD, 1, 0, 6'd0, 0, 6'd0, 0);
    p.valid = 1'b0;
    drive(p, 0, 0);
    chk("invalid_ld_drop", bv(), 5'b00000);

    // Mid-operation reset discards held entries
    drive(mk(15, ALU_ADD, 0, 0, 6'd13, 1, 6'd14, 1), 0, 0);
    chk("pre_reset_busy", bv(), 5'b10000);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_reset_busy", bv(), 5'b00000);
    chk("mid_reset_issue", {4'b0, issue}, 5'b0);
    @(negedge clock);
    reset = 1'b1;
    drive('0, 6'd13, 1);
    drive('0, 6'd14, 1);
    cyc();
    cyc();
    chk("post_reset_idle", bv(), 5'b00000);

    // Every expected issue must have been seen
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
